xyolo_int_seq: RTL and testbench

//  Internal-port sequencer for the yolo write stage. Drives vread_enB/vread_addrB (tap reads), ld_acc/ld_mp/ld_res (xyolo load

---
 rtl/xyolo_int_seq_if.sv | 37 +++
 rtl/xyolo_int_seq.sv | 185 ++++++++++++++++++
 tb/tb_xyolo_int_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/xyolo_int_seq_if.sv
// Port bundle of the yolo write-stage internal sequencer: run/done, configuration,
// vread tap-read port, xyolo load strobes and vwrite result-write port.
interface xyolo_int_seq_if #(
  parameter int MEM_ADDR_W    = 10,
  parameter int VWRITE_ADDR_W = 10,
  parameter int PERIOD_W      = 10
);
  logic                     run;
  logic                     done;
  logic [MEM_ADDR_W-1:0]    cfg_iter;
  logic [PERIOD_W-1:0]      cfg_per;
  logic [MEM_ADDR_W-1:0]    cfg_rd_start;
  logic [MEM_ADDR_W-1:0]    cfg_rd_incr;
  logic [MEM_ADDR_W-1:0]    cfg_rd_shift;
  logic [VWRITE_ADDR_W-1:0] cfg_wr_start;
  logic [VWRITE_ADDR_W-1:0] cfg_wr_incr;
  logic                     cfg_maxpool;
  logic                     vread_enB;
  logic [MEM_ADDR_W-1:0]    vread_addrB;
  logic                     ld_acc;
  logic                     ld_mp;
  logic                     ld_res;
  logic                     vwrite_enB;
  logic [VWRITE_ADDR_W-1:0] vwrite_addrB;

  modport master (
    output run, cfg_iter, cfg_per, cfg_rd_start, cfg_rd_incr, cfg_rd_shift,
           cfg_wr_start, cfg_wr_incr, cfg_maxpool,
    input  done, vread_enB, vread_addrB, ld_acc, ld_mp, ld_res, vwrite_enB, vwrite_addrB
  );

  modport slave (
    input  run, cfg_iter, cfg_per, cfg_rd_start, cfg_rd_incr, cfg_rd_shift,
           cfg_wr_start, cfg_wr_incr, cfg_maxpool,
    output done, vread_enB, vread_addrB, ld_acc, ld_mp, ld_res, vwrite_enB, vwrite_addrB
  );
endinterface

// File: rtl/xyolo_int_seq.sv
// Internal-port sequencer for the yolo write stage: issues ITER x PER tap reads and
// delay-aligns the xyolo load strobes and result writes to the vread + xyolo pipeline.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | done=1, outputs quiet, waiting for run
//  S_ISSUE | one tap read per cycle until ITER*PER reads are issued
//  S_DRAIN | no new reads; in-flight tags and the last write retire
module xyolo_int_seq #(
  parameter int MEM_ADDR_W    = 10,
  parameter int VWRITE_ADDR_W = 10,
  parameter int PERIOD_W      = 10,
  parameter int RD_LAT        = 2,
  parameter int RES_LAT       = 2
) (
  input  logic            clk,
  input  logic            rst,
  xyolo_int_seq_if.slave  bus
);

  localparam int RES_DLY = RD_LAT + RES_LAT;
  localparam int DRAIN_W = $clog2(RES_DLY + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [MEM_ADDR_W-1:0]    iter_r;
  logic [PERIOD_W-1:0]      per_r;
  logic [MEM_ADDR_W-1:0]    rd_incr_r;
  logic [MEM_ADDR_W-1:0]    rd_shift_r;
  logic [VWRITE_ADDR_W-1:0] wr_incr_r;
  logic                     maxpool_r;

  logic [PERIOD_W-1:0]      tap;
  logic [MEM_ADDR_W-1:0]    outp;
  logic [MEM_ADDR_W-1:0]    rd_addr;
  logic [VWRITE_ADDR_W-1:0] wr_addr;
  logic [DRAIN_W-1:0]       drain_cnt;

  logic [RD_LAT-1:0]        first_sr;
  logic [RES_DLY-1:0]       last_sr;
  logic [1:0]               mp_cnt;
  logic                     wr_pend;

  logic issue;
  logic tap_first;
  logic tap_last;
  logic out_last;
  logic cfg_zero;
  logic ld_acc;
  logic ld_res;
  logic ld_mp;

  assign issue     = (state == S_ISSUE);
  assign tap_first = (tap == '0);
  assign tap_last  = (tap == per_r - PERIOD_W'(1));
  assign out_last  = (outp == iter_r - MEM_ADDR_W'(1));
  assign cfg_zero  = (bus.cfg_iter == '0) || (bus.cfg_per == '0);

  assign ld_acc = first_sr[RD_LAT-1];
  assign ld_res = last_sr[RES_DLY-1];
  assign ld_mp  = ld_res & maxpool_r & (mp_cnt == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.run) begin
          state_nx = cfg_zero ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tap_last && out_last) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Tag pipeline: first/last markers travel with each read to the xyolo input and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_sr <= '0;
      last_sr  <= '0;
      wr_pend  <= 1'b0;
    end else begin
      first_sr <= (first_sr << 1) | RD_LAT'(issue && tap_first);
      last_sr  <= (last_sr << 1) | RES_DLY'(issue && tap_last);
      wr_pend  <= ld_res && (!maxpool_r || (mp_cnt == 2'd3));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_r     <= '0;
      per_r      <= '0;
      rd_incr_r  <= '0;
      rd_shift_r <= '0;
      wr_incr_r  <= '0;
      maxpool_r  <= 1'b0;
      tap        <= '0;
      outp       <= '0;
      rd_addr    <= '0;
      wr_addr    <= '0;
      drain_cnt  <= '0;
      mp_cnt     <= 2'd0;
    end else begin
      if (ld_res && maxpool_r) begin
        mp_cnt <= mp_cnt + 2'd1;
      end
      if (wr_pend) begin
        wr_addr <= wr_addr + wr_incr_r;
      end
      case (state)
        S_IDLE: begin
          if (bus.run) begin
            iter_r     <= bus.cfg_iter;
            per_r      <= bus.cfg_per;
            rd_incr_r  <= bus.cfg_rd_incr;
            rd_shift_r <= bus.cfg_rd_shift;
            wr_incr_r  <= bus.cfg_wr_incr;
            maxpool_r  <= bus.cfg_maxpool;
            tap        <= '0;
            outp       <= '0;
            rd_addr    <= bus.cfg_rd_start;
            wr_addr    <= bus.cfg_wr_start;
            drain_cnt  <= '0;
            mp_cnt     <= 2'd0;
          end
        end
        S_ISSUE: begin
          if (tap_last) begin
            tap     <= '0;
            outp    <= outp + MEM_ADDR_W'(1);
            rd_addr <= rd_addr + rd_incr_r + rd_shift_r;
            if (out_last) begin
              // Holds DRAIN until the last read's result write has been issued.
              drain_cnt <= DRAIN_W'(RES_DLY);
            end
          end else begin
            tap     <= tap + PERIOD_W'(1);
            rd_addr <= rd_addr + rd_incr_r;
          end
        end
        S_DRAIN: begin
          if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        default: begin
          drain_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.done         = (state == S_IDLE);
  assign bus.vread_enB    = issue;
  assign bus.vread_addrB  = issue ? rd_addr : '0;
  assign bus.ld_acc       = ld_acc;
  assign bus.ld_res       = ld_res;
  assign bus.ld_mp        = ld_mp;
  assign bus.vwrite_enB   = wr_pend;
  assign bus.vwrite_addrB = wr_pend ? wr_addr : '0;

endmodule

// File: tb/tb_xyolo_int_seq.sv
// Scoreboard bench for xyolo_int_seq: expected events (cycle, address) are queued per
// output when a run is issued; a negedge monitor pops and compares as the DUT emits them.
module tb_xyolo_int_seq;

  localparam int AW = 10;
  localparam int WW = 10;
  localparam int PW = 10;
  localparam int AMOD = 1 << AW;
  localparam int WMOD = 1 << WW;

  typedef struct {
    int cyc;
    int addr;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic done_prev = 1'b1;

  ev_t q_rd[$];
  ev_t q_acc[$];
  ev_t q_res[$];
  ev_t q_mp[$];
  ev_t q_wr[$];
  ev_t q_done[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xyolo_int_seq_if #(.MEM_ADDR_W(AW), .VWRITE_ADDR_W(WW), .PERIOD_W(PW)) bus ();

  xyolo_int_seq #(
    .MEM_ADDR_W(AW), .VWRITE_ADDR_W(WW), .PERIOD_W(PW), .RD_LAT(2), .RES_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: derives every event directly from the run parameters.
  task automatic push_run(input int iter, input int per, input int rs, input int ri,
                          input int rsh, input int ws, input int wi, input int mp,
                          input int e0);
    int j, rc;
    if (iter == 0 || per == 0) begin
      q_done.push_back('{e0 + 1, 0});
      return;
    end
    for (int i = 0; i < iter; i++) begin
      for (int t = 0; t < per; t++) begin
        j = i * per + t;
        q_rd.push_back('{e0 + j, (rs + i * (per * ri + rsh) + t * ri) % AMOD});
        if (t == 0) q_acc.push_back('{e0 + j + 2, 0});
        if (t == per - 1) begin
          rc = e0 + j + 4;
          q_res.push_back('{rc, 0});
          if (mp != 0) begin
            if (i % 4 == 0) q_mp.push_back('{rc, 0});
            if (i % 4 == 3) q_wr.push_back('{rc + 1, (ws + (i / 4) * wi) % WMOD});
          end else begin
            q_wr.push_back('{rc + 1, (ws + i * wi) % WMOD});
          end
        end
      end
    end
    q_done.push_back('{e0 + iter * per + 5, 0});
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (mon_en) begin
      if (q_rd.size() > 0 && q_rd[0].cyc < cyc) begin chk("rd_missed", cyc, q_rd[0].cyc); void'(q_rd.pop_front()); end
      if (q_acc.size() > 0 && q_acc[0].cyc < cyc) begin chk("acc_missed", cyc, q_acc[0].cyc); void'(q_acc.pop_front()); end
      if (q_res.size() > 0 && q_res[0].cyc < cyc) begin chk("res_missed", cyc, q_res[0].cyc); void'(q_res.pop_front()); end
      if (q_mp.size() > 0 && q_mp[0].cyc < cyc) begin chk("mp_missed", cyc, q_mp[0].cyc); void'(q_mp.pop_front()); end
      if (q_wr.size() > 0 && q_wr[0].cyc < cyc) begin chk("wr_missed", cyc, q_wr[0].cyc); void'(q_wr.pop_front()); end

      if (bus.vread_enB === 1'b1) begin
        chk("rd_expected", int'(q_rd.size() > 0), 1);
        if (q_rd.size() > 0) begin
          e = q_rd.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_addr", int'(bus.vread_addrB), e.addr);
        end
      end
      if (bus.ld_acc === 1'b1) begin
        chk("acc_expected", int'(q_acc.size() > 0), 1);
        if (q_acc.size() > 0) begin e = q_acc.pop_front(); chk("acc_cycle", cyc, e.cyc); end
      end
      if (bus.ld_res === 1'b1) begin
        chk("res_expected", int'(q_res.size() > 0), 1);
        if (q_res.size() > 0) begin e = q_res.pop_front(); chk("res_cycle", cyc, e.cyc); end
      end
      if (bus.ld_mp === 1'b1) begin
        chk("mp_expected", int'(q_mp.size() > 0), 1);
        if (q_mp.size() > 0) begin e = q_mp.pop_front(); chk("mp_cycle", cyc, e.cyc); end
      end
      if (bus.vwrite_enB === 1'b1) begin
        chk("wr_expected", int'(q_wr.size() > 0), 1);
        if (q_wr.size() > 0) begin
          e = q_wr.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", int'(bus.vwrite_addrB), e.addr);
        end
      end
      if (bus.done === 1'b1 && done_prev === 1'b0) begin
        chk("done_expected", int'(q_done.size() > 0), 1);
        if (q_done.size() > 0) begin e = q_done.pop_front(); chk("done_cycle", cyc, e.cyc); end
      end
      done_prev = bus.done;
    end
  end

  task automatic check_quiet(input string nm);
    chk({nm, "_done"}, int'(bus.done), 1);
    chk({nm, "_strobes"}, int'({bus.vread_enB, bus.ld_acc, bus.ld_res, bus.ld_mp, bus.vwrite_enB}), 0);
    chk({nm, "_addrs"}, int'(bus.vread_addrB) + int'(bus.vwrite_addrB), 0);
  endtask

  task automatic check_leftover();
    chk("left_rd", q_rd.size(), 0);
    chk("left_acc", q_acc.size(), 0);
    chk("left_res", q_res.size(), 0);
    chk("left_mp", q_mp.size(), 0);
    chk("left_wr", q_wr.size(), 0);
    chk("left_done", q_done.size(), 0);
    q_rd.delete(); q_acc.delete(); q_res.delete(); q_mp.delete(); q_wr.delete(); q_done.delete();
  endtask

  task automatic drive_cfg(input int iter, input int per, input int rs, input int ri,
                           input int rsh, input int ws, input int wi, input int mp);
    bus.cfg_iter     = AW'(iter);
    bus.cfg_per      = PW'(per);
    bus.cfg_rd_start = AW'(rs);
    bus.cfg_rd_incr  = AW'(ri);
    bus.cfg_rd_shift = AW'(rsh);
    bus.cfg_wr_start = WW'(ws);
    bus.cfg_wr_incr  = WW'(wi);
    bus.cfg_maxpool  = mp[0];
  endtask

  task automatic do_run(input int iter, input int per, input int rs, input int ri,
                        input int rsh, input int ws, input int wi, input int mp,
                        input int extra_at);
    int n;
    drive_cfg(iter, per, rs, ri, rsh, ws, wi, mp);
    bus.run = 1'b1;
    push_run(iter, per, rs, ri, rsh, ws, wi, mp, cyc + 1);
    tick();
    bus.run = 1'b0;
    // Configuration must have been captured at run; scramble it for the rest of the run.
    drive_cfg($urandom_range(1, 9), $urandom_range(1, 9), $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom_range(0, 1));
    n = 0;
    while (bus.done !== 1'b1 && n < iter * per + 40) begin
      bus.run = (n == extra_at);
      tick();
      n++;
    end
    bus.run = 1'b0;
    chk("done_reached", int'(bus.done === 1'b1), 1);
    tick();
    tick();
    check_quiet("idle_after_run");
    check_leftover();
  endtask

  initial begin
    int iter, per, ex;
    bus.run = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    check_quiet("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    do_run(2, 3, 0, 1, 2, 40, 3, 0, -1);
    do_run(8, 1, 5, 2, 0, 100, 7, 1, -1);
    do_run(6, 2, 9, 1, 0, 200, 1, 1, -1);
    do_run(0, 4, 3, 1, 1, 0, 1, 0, -1);
    do_run(3, 0, 3, 1, 1, 0, 1, 1, -1);
    do_run(3, 2, 1020, 1, 1, 1022, 1, 0, -1);
    do_run(4, 3, 10, 2, 5, 50, 2, 0, 4);

    // Reset in the third issue cycle of a 4x4 run, then a clean restart.
    drive_cfg(4, 4, 100, 1, 3, 300, 1, 0);
    bus.run = 1'b1;
    push_run(4, 4, 100, 1, 3, 300, 1, 0, cyc + 1);
    tick();
    bus.run = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_rd.delete(); q_acc.delete(); q_res.delete(); q_mp.delete(); q_wr.delete(); q_done.delete();
    q_done.push_back('{cyc, 0});
    check_quiet("abort");
    tick();
    tick();
    check_leftover();
    do_run(4, 4, 100, 1, 3, 300, 1, 0, -1);

    for (int r = 0; r < 25; r++) begin
      iter = $urandom_range(0, 7);
      per  = $urandom_range(0, 5);
      ex   = -1;
      if (iter * per > 1 && $urandom_range(0, 1) == 1) ex = $urandom_range(0, iter * per - 1);
      do_run(iter, per, $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1),
             $urandom_range(0, AMOD - 1), $urandom_range(0, WMOD - 1),
             $urandom_range(0, WMOD - 1), $urandom_range(0, 1), ex);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
